// File: rtl/sub_pkg.sv
// Shared types and elaboration helpers for the chunked serial subtractor.
package sub_pkg;

  typedef enum logic [1:0] {
    SUB_IDLE = 2'd0,
    SUB_RUN  = 2'd1,
    SUB_DONE = 2'd2
  } sub_state_e;

  // Chunk counter width: ceil(log2(N)) with N = width / bpc, never below 1.
  function automatic int sub_cnt_width(input int width, input int bpc);
    int n;
    n = width / bpc;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: two half-subtractor stages with their borrows ORed.
module full_subtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  logic hs1_d;
  logic hs1_b;
  logic hs2_b;

  assign hs1_d  = a_i ^ b_i;
  assign hs1_b  = ~a_i & b_i;

  assign d_o    = hs1_d ^ bin_i;
  assign hs2_b  = ~hs1_d & bin_i;

  assign bout_o = hs1_b | hs2_b;

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b, BITS_PER_CYCLE bits per clock, LSB chunk
// first, borrow carried between chunks in a register; start/busy/done handshake.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int N     = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = sub_cnt_width(WIDTH, BITS_PER_CYCLE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("serial_subtractor: WIDTH must be at least 2");
  end
  if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_bpc
    $error("serial_subtractor: BITS_PER_CYCLE must divide WIDTH");
  end

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bor_q, bor_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic [BITS_PER_CYCLE-1:0]       chunk_diff;
  logic                            chunk_bout;
  logic [WIDTH+BITS_PER_CYCLE-1:0] res_ext;
  logic [WIDTH-1:0]                res_shift;

  // Chunk ripple; each stage keeps its own borrow net so the chain is
  // a set of independent scalars rather than one self-referencing vector.
  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
    logic bi;
    logic bo;
    if (i == 0) begin : g_first
      assign bi = bor_q;
    end else begin : g_next
      assign bi = g_cell[i-1].bo;
    end
    full_subtractor u_fs (
      .a_i    (a_q[i]),
      .b_i    (b_q[i]),
      .bin_i  (bi),
      .d_o    (chunk_diff[i]),
      .bout_o (bo)
    );
  end

  assign chunk_bout = g_cell[BITS_PER_CYCLE-1].bo;

  // New chunk enters at the top; after N chunks the first one sits at bit 0.
  assign res_ext   = {chunk_diff, res_q};
  assign res_shift = WIDTH'(res_ext >> BITS_PER_CYCLE);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case leaves one unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    bor_d    = bor_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    case (state_q)
      SUB_IDLE, SUB_DONE: begin
        state_d = SUB_IDLE;
        if (start) begin
          state_d = SUB_RUN;
          a_d     = a;
          b_d     = b;
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
          res_d   = '0;
          bor_d   = 1'b0;
          cnt_d   = '0;
        end
      end

      SUB_RUN: begin
        a_d   = a_q >> BITS_PER_CYCLE;
        b_d   = b_q >> BITS_PER_CYCLE;
        res_d = res_shift;
        bor_d = chunk_bout;
        cnt_d = cnt_q + CNT_W'(1);
        // Result registers load on the last chunk edge so they are valid in DONE.
        if (cnt_q == LAST_CNT) begin
          state_d  = SUB_DONE;
          diff_d   = res_shift;
          borrow_d = chunk_bout;
          ovf_d    = (a_msb_q ^ b_msb_q) & (res_shift[WIDTH-1] ^ a_msb_q);
        end
      end

      default: state_d = SUB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SUB_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      bor_q    <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      bor_q    <= bor_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == SUB_RUN);
  assign done     = (state_q == SUB_DONE);
  assign diff     = diff_q;
  assign borrow   = borrow_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: an 8-bit/1-bit-per-cycle instance and
// a 16-bit/4-bits-per-cycle instance driven with start held high.
module tb_serial_subtractor;

  typedef struct packed {
    logic [15:0] diff;
    logic        borrow;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, borrow8, ovf8;
  logic [7:0]  diff8;

  logic        start16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, borrow16, ovf16;
  logic [15:0] diff16;

  exp_t q8[$];
  exp_t q16[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(borrow8), .overflow(ovf8)
  );

  serial_subtractor #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow(borrow16), .overflow(ovf16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model8(input logic [7:0] a, input logic [7:0] b);
    exp_t       e;
    logic [7:0] d;
    d        = a - b;
    e.diff   = {8'h00, d};
    e.borrow = (a < b);
    e.ovf    = (a[7] != b[7]) && (d[7] != a[7]);
    return e;
  endfunction

  function automatic exp_t model16(input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [15:0] d;
    d        = a - b;
    e.diff   = d;
    e.borrow = (a < b);
    e.ovf    = (a[15] != b[15]) && (d[15] != a[15]);
    return e;
  endfunction

  // One 8-bit operation; optionally pulses start with junk operands on RUN cycle inject_at.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input int inject_at);
    int   busy_cnt;
    logic got_done;
    exp_t e;
    q8.push_back(model8(a, b));
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8   = 1'b0;
    busy_cnt = 0;
    got_done = 1'b0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      if (busy8) busy_cnt++;
      if (done8) begin
        got_done = 1'b1;
      end else begin
        if (c == inject_at) begin
          a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
        end else begin
          start8 = 1'b0;
        end
        @(negedge clk);
      end
    end
    start8 = 1'b0;
    check("d8_busy_len", 32'(busy_cnt), 32'd8);
    check("d8_done_seen", {31'd0, got_done}, 32'd1);
    if (got_done) begin
      e = q8.pop_front();
      check("d8_diff", {24'd0, diff8}, {16'd0, e.diff});
      check("d8_borrow", {31'd0, borrow8}, {31'd0, e.borrow});
      check("d8_ovf", {31'd0, ovf8}, {31'd0, e.ovf});
      @(negedge clk);
      check("d8_done_pulse", {31'd0, done8}, 32'd0);
    end
  endtask

  initial begin
    int   n_done;
    int   prev_done;
    int   stray_done;
    logic [15:0] last16;
    exp_t e;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy8", {31'd0, busy8}, 32'd0);
    check("rst_done8", {31'd0, done8}, 32'd0);
    check("rst_diff8", {24'd0, diff8}, 32'd0);
    check("rst_flags8", {30'd0, borrow8, ovf8}, 32'd0);
    check("rst_busy16", {31'd0, busy16}, 32'd0);
    check("rst_diff16", {16'd0, diff16}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op8(8'h05, 8'h03, -1);
    op8(8'h03, 8'h05, -1);
    op8(8'h00, 8'hFF, -1);
    op8(8'h80, 8'h01, -1);
    op8(8'h7F, 8'hFF, -1);
    op8(8'h5A, 8'h33, 2);

    // Abort mid-RUN: reset on the 4th RUN cycle clears everything with no done.
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_run", {31'd0, busy8}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy8}, 32'd0);
    check("abort_done", {31'd0, done8}, 32'd0);
    check("abort_diff", {24'd0, diff8}, 32'd0);
    check("abort_flags", {30'd0, borrow8, ovf8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    stray_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done8 || busy8) stray_done++;
    end
    check("abort_no_done", 32'(stray_done), 32'd0);

    op8(8'h09, 8'h04, -1);
    for (int i = 0; i < 4; i++) begin
      op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), -1);
    end

    // 16-bit, 4 bits/cycle, start held: one result every N+1 = 5 cycles.
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h0235; start16 = 1'b1;
    q16.push_back(model16(a16, b16));
    prev_done = -1;
    n_done    = 0;
    last16    = 16'h0000;
    for (int cyc = 0; cyc < 60 && n_done < 4; cyc++) begin
      @(negedge clk);
      if (done16) begin
        e = q16.pop_front();
        check("d16_diff", {16'd0, diff16}, {16'd0, e.diff});
        check("d16_borrow", {31'd0, borrow16}, {31'd0, e.borrow});
        check("d16_ovf", {31'd0, ovf16}, {31'd0, e.ovf});
        check("d16_busy_in_done", {31'd0, busy16}, 32'd0);
        if (prev_done >= 0) check("d16_period", 32'(cyc - prev_done), 32'd5);
        prev_done = cyc;
        last16    = e.diff;
        n_done++;
        if (n_done < 4) begin
          a16 = 16'($urandom_range(0, 65535));
          b16 = 16'($urandom_range(0, 65535));
          q16.push_back(model16(a16, b16));
        end else begin
          start16 = 1'b0;
        end
      end else begin
        check("d16_hold", {16'd0, diff16}, {16'd0, last16});
      end
    end
    start16 = 1'b0;
    check("d16_count", 32'(n_done), 32'd4);
    check("q8_empty", 32'(q8.size()), 32'd0);
    check("q16_empty", 32'(q16.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
